// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
//   hz_state_e : controller FSM state (RUN, MC_BUSY)
//   MC_LAT_MIN / MC_LAT_MAX : legal range for the multi-cycle EX latency
//   MC_CNT_W   : width of the multi-cycle down-counter
package hazard_pkg;

  typedef enum logic {
    RUN     = 1'b0,
    MC_BUSY = 1'b1
  } hz_state_e;

  localparam int unsigned MC_LAT_MIN = 2;
  localparam int unsigned MC_LAT_MAX = 64;
  localparam int unsigned MC_CNT_W   = 6;

endpackage

// File: rtl/hazard_perf_cnt.sv
// 32-bit saturating performance counter.
//   clk : clock
//   clr : synchronous clear, has priority over inc
//   inc : count one event this cycle
//   cnt : current count, sticks at all-ones
module hazard_perf_cnt (
  input  logic        clk,
  input  logic        clr,
  input  logic        inc,
  output logic [31:0] cnt
);

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt <= 32'd0;
    end else if (inc && (cnt != 32'hFFFF_FFFF)) begin
      cnt <= cnt + 32'd1;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: produces PC / pipeline-register enables and
// flushes from memory wait, multi-cycle EX ops, EX redirects and load-use
// hazards, and counts stall and flush cycles.
//   clk, rst                       : clock, synchronous active-high reset
//   id_rs1/id_rs2, id_use_rs1/2    : ID source registers and their use flags
//   ex_rd, ex_reg_write, ex_mem_read : EX destination and instruction type
//   ex_redirect, ex_mc_start       : EX taken branch/jump; EX holds multi-cycle op
//   mem_req, mem_ready             : MEM data access and its completion
//   *_en, *_flush                  : register enables / bubble inserts
//   stall_cnt, flush_cnt           : saturating performance counters
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned MC_LAT = 32,
  parameter int unsigned RA_W   = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [RA_W-1:0] id_rs1,
  input  logic [RA_W-1:0] id_rs2,
  input  logic            id_use_rs1,
  input  logic            id_use_rs2,
  input  logic [RA_W-1:0] ex_rd,
  input  logic            ex_reg_write,
  input  logic            ex_mem_read,
  input  logic            ex_redirect,
  input  logic            ex_mc_start,
  input  logic            mem_req,
  input  logic            mem_ready,
  output logic            pc_en,
  output logic            ifid_en,
  output logic            idex_en,
  output logic            exmem_en,
  output logic            memwb_en,
  output logic            ifid_flush,
  output logic            idex_flush,
  output logic            exmem_flush,
  output logic            memwb_flush,
  output logic [31:0]     stall_cnt,
  output logic [31:0]     flush_cnt
);

  if ((MC_LAT < MC_LAT_MIN) || (MC_LAT > MC_LAT_MAX)) begin : g_bad_mc_lat
    $error("hazard_ctrl: MC_LAT out of range");
  end

  // First multi-cycle stall happens in RUN, the last EX cycle is the mc_cnt==0
  // cycle in MC_BUSY, so MC_LAT-2 decrements fill the remainder.
  localparam logic [MC_CNT_W-1:0] McLoad = MC_CNT_W'(MC_LAT - 2);

  hz_state_e             state_q, state_d;
  logic [MC_CNT_W-1:0]   mc_cnt_q, mc_cnt_d;

  logic mem_wait;
  logic mc_stall;
  logic load_use;
  logic redirect_apply;

  assign mem_wait = mem_req & ~mem_ready;
  assign mc_stall = (state_q == RUN) ? ex_mc_start : (mc_cnt_q != '0);
  assign load_use = ex_mem_read & ex_reg_write & (ex_rd != '0) &
                    ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RUN;
      mc_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      mc_cnt_q <= mc_cnt_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    mc_cnt_d       = mc_cnt_q;
    redirect_apply = 1'b0;
    pc_en          = 1'b1;
    ifid_en        = 1'b1;
    idex_en        = 1'b1;
    exmem_en       = 1'b1;
    memwb_en       = 1'b1;
    ifid_flush     = 1'b0;
    idex_flush     = 1'b0;
    exmem_flush    = 1'b0;
    memwb_flush    = 1'b0;

    if (rst) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_en    = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      memwb_flush = 1'b1;
    end else if (mem_wait) begin
      // Everything up to MEM freezes; a pending ex_redirect stays in EX and
      // is applied once the access completes.
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_flush = 1'b1;
    end else if (mc_stall) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_flush = 1'b1;
      if (state_q == RUN) begin
        mc_cnt_d = McLoad;
        state_d  = MC_BUSY;
      end else begin
        mc_cnt_d = mc_cnt_q - MC_CNT_W'(1);
      end
    end else begin
      // In MC_BUSY reaching here means mc_cnt==0: the result moves on now.
      if (state_q == MC_BUSY) begin
        state_d = RUN;
      end
      if (ex_redirect) begin
        // ID holds a wrong-path instruction, so any load-use there is moot.
        redirect_apply = 1'b1;
        ifid_flush     = 1'b1;
        idex_flush     = 1'b1;
      end else if (load_use) begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_flush = 1'b1;
      end
    end
  end

  hazard_perf_cnt u_stall_cnt (
    .clk (clk),
    .clr (rst),
    .inc (~pc_en),
    .cnt (stall_cnt)
  );

  hazard_perf_cnt u_flush_cnt (
    .clk (clk),
    .clr (rst),
    .inc (redirect_apply),
    .cnt (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl with MC_LAT=4.
module tb_hazard_ctrl;
  import hazard_pkg::*;

  localparam int unsigned MC_LAT = 4;
  localparam int unsigned RA_W   = 5;

  logic            clk;
  logic            rst;
  logic [RA_W-1:0] id_rs1, id_rs2, ex_rd;
  logic            id_use_rs1, id_use_rs2, ex_reg_write, ex_mem_read;
  logic            ex_redirect, ex_mc_start, mem_req, mem_ready;
  logic            pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic            ifid_flush, idex_flush, exmem_flush, memwb_flush;
  logic [31:0]     stall_cnt, flush_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int occ;
  bit done;

  hazard_ctrl #(
    .MC_LAT (MC_LAT),
    .RA_W   (RA_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_use_rs1   (id_use_rs1),
    .id_use_rs2   (id_use_rs2),
    .ex_rd        (ex_rd),
    .ex_reg_write (ex_reg_write),
    .ex_mem_read  (ex_mem_read),
    .ex_redirect  (ex_redirect),
    .ex_mc_start  (ex_mc_start),
    .mem_req      (mem_req),
    .mem_ready    (mem_ready),
    .pc_en        (pc_en),
    .ifid_en      (ifid_en),
    .idex_en      (idex_en),
    .exmem_en     (exmem_en),
    .memwb_en     (memwb_en),
    .ifid_flush   (ifid_flush),
    .idex_flush   (idex_flush),
    .exmem_flush  (exmem_flush),
    .memwb_flush  (memwb_flush),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Enables packed {pc, ifid, idex, exmem, memwb}; flushes {ifid, idex, exmem, memwb}.
  wire [4:0] en = {pc_en, ifid_en, idex_en, exmem_en, memwb_en};
  wire [3:0] fl = {ifid_flush, idex_flush, exmem_flush, memwb_flush};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
    id_use_rs1 = 0; id_use_rs2 = 0; ex_reg_write = 0; ex_mem_read = 0;
    ex_redirect = 0; ex_mc_start = 0; mem_req = 0; mem_ready = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic set_load_use(input logic [RA_W-1:0] rd);
    ex_mem_read = 1; ex_reg_write = 1; ex_rd = rd; id_use_rs1 = 1; id_rs1 = rd;
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    // Reset state
    check("rst_en", 32'(en), 32'h00);
    check("rst_flush", 32'(fl), 32'hF);
    check("rst_stall_cnt", stall_cnt, 0);
    check("rst_flush_cnt", flush_cnt, 0);
    check("rst_state", 32'(dut.state_q), 32'(RUN));
    rst = 1'b0;
    #1;
    check("post_rst_en", 32'(en), 32'h1F);
    check("post_rst_flush", 32'(fl), 32'h0);

    // Load-use on rs1, x5
    set_load_use(5'd5);
    #1;
    check("lu_en", 32'(en), 32'h07);
    check("lu_flush", 32'(fl), 32'h4);
    tick();
    clear_inputs();
    #1;
    check("lu_stall_cnt", stall_cnt, 1);
    check("lu_after_en", 32'(en), 32'h1F);

    // x0 destination: no hazard
    do_reset();
    set_load_use(5'd0);
    #1;
    check("x0_en", 32'(en), 32'h1F);
    tick();
    clear_inputs();
    check("x0_stall_cnt", stall_cnt, 0);

    // rs2 match but not read: no hazard; then read: hazard
    ex_mem_read = 1; ex_reg_write = 1; ex_rd = 5'd9; id_rs2 = 5'd9; id_use_rs2 = 0;
    #1;
    check("rs2_unused_en", 32'(en), 32'h1F);
    id_use_rs2 = 1;
    #1;
    check("rs2_used_en", 32'(en), 32'h07);
    tick();
    clear_inputs();
    check("rs2_stall_cnt", stall_cnt, 1);

    // Redirect overrides load-use
    do_reset();
    set_load_use(5'd5);
    ex_redirect = 1;
    #1;
    check("rd_lu_en", 32'(en), 32'h1F);
    check("rd_lu_flush", 32'(fl), 32'hC);
    tick();
    clear_inputs();
    check("rd_lu_flush_cnt", flush_cnt, 1);
    check("rd_lu_stall_cnt", stall_cnt, 0);

    // Multi-cycle op, MC_LAT=4: three stalls then release
    do_reset();
    ex_mc_start = 1;
    for (int c = 0; c < 4; c++) begin
      #1;
      check($sformatf("mc_en_%0d", c), 32'(en), (c < 3) ? 32'h03 : 32'h1F);
      check($sformatf("mc_flush_%0d", c), 32'(fl), (c < 3) ? 32'h2 : 32'h0);
      tick();
    end
    ex_mc_start = 0;
    #1;
    check("mc_state_run", 32'(dut.state_q), 32'(RUN));
    check("mc_stall_cnt", stall_cnt, 3);
    check("mc_idle_en", 32'(en), 32'h1F);

    // mem_wait for 2 cycles while mc_cnt==1 stretches EX to MC_LAT+2
    do_reset();
    ex_mc_start = 1;
    occ = 0;
    done = 0;
    for (int c = 1; c <= 20 && !done; c++) begin
      mem_req = (c == 3 || c == 4);
      mem_ready = 0;
      #1;
      occ = c;
      if (c == 3) begin
        check("mw_mc_cnt_before", 32'(dut.mc_cnt_q), 1);
        check("mw_en", 32'(en), 32'h01);
        check("mw_flush", 32'(fl), 32'h1);
      end
      if (idex_en) done = 1;
      tick();
      if (c == 3 || c == 4) check($sformatf("mw_mc_cnt_hold_%0d", c), 32'(dut.mc_cnt_q), 1);
    end
    ex_mc_start = 0;
    mem_req = 0;
    check("mw_occupancy", occ, MC_LAT + 2);
    check("mw_stall_cnt", stall_cnt, MC_LAT + 1);

    // Redirect coinciding with mem_wait is applied once the access completes
    do_reset();
    ex_redirect = 1; mem_req = 1; mem_ready = 0;
    #1;
    check("rdmw_wait_en", 32'(en), 32'h01);
    check("rdmw_wait_flush", 32'(fl), 32'h1);
    tick();
    check("rdmw_wait_flush_cnt", flush_cnt, 0);
    mem_ready = 1;
    #1;
    check("rdmw_go_en", 32'(en), 32'h1F);
    check("rdmw_go_flush", 32'(fl), 32'hC);
    tick();
    clear_inputs();
    check("rdmw_flush_cnt", flush_cnt, 1);
    check("rdmw_stall_cnt", stall_cnt, 1);

    // Reset during MC_BUSY abandons the op
    ex_mc_start = 1;
    tick();
    tick();
    check("rb_busy", 32'(dut.state_q), 32'(MC_BUSY));
    ex_mc_start = 0;
    rst = 1;
    #1;
    check("rb_rst_en", 32'(en), 32'h00);
    tick();
    rst = 0;
    #1;
    check("rb_state", 32'(dut.state_q), 32'(RUN));
    check("rb_mc_cnt", 32'(dut.mc_cnt_q), 0);
    check("rb_stall_cnt", stall_cnt, 0);
    check("rb_flush_cnt", flush_cnt, 0);
    check("rb_en", 32'(en), 32'h1F);
    check("rb_flush", 32'(fl), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
